// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: pipeline enables/flushes for load-use, taken branches and multi-cycle memory freezes
module pipeline_hazard_controller #(
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int MEM_LATENCY     = 3,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [REG_ADDR_WIDTH-1:0]  idRs,
  input  logic [REG_ADDR_WIDTH-1:0]  idRt,
  input  logic                       idUsesRt,
  input  logic                       exMemRead,
  input  logic [REG_ADDR_WIDTH-1:0]  exRd,
  input  logic                       exBranchTaken,
  input  logic                       memAccess,
  output logic                       pcEnable,
  output logic                       ifIdEnable,
  output logic                       idExEnable,
  output logic                       exMemEnable,
  output logic                       memWbEnable,
  output logic                       ifIdFlush,
  output logic                       idExFlush,
  output logic                       memWbBubble,
  output logic                       busy,
  output logic [STALL_CNT_WIDTH-1:0] stallCycles
);
  typedef enum logic {RUN, WAIT} state_t;
  state_t                     r_state;
  logic [3:0]                 r_wait_cnt;
  logic [STALL_CNT_WIDTH-1:0] r_stall;
  logic w_load_use, w_freeze, w_branch, w_stall;
  assign w_load_use = exMemRead && exRd != '0 && (exRd == idRs || (idUsesRt && exRd == idRt));
  // The release cycle (WAIT, count 0) ignores memAccess: the same instruction is still in MEM
  assign w_freeze = (r_state == RUN && memAccess && MEM_LATENCY > 1) || (r_state == WAIT && r_wait_cnt != 4'd0);
  assign w_branch = !w_freeze && exBranchTaken;
  assign w_stall  = !w_freeze && !exBranchTaken && w_load_use;
  assign pcEnable    = reset && !w_freeze && !w_stall;
  assign ifIdEnable  = reset && !w_freeze && !w_stall;
  assign idExEnable  = reset && !w_freeze;
  assign exMemEnable = reset && !w_freeze;
  assign memWbEnable = reset && !w_freeze;
  assign ifIdFlush   = reset && w_branch;
  assign idExFlush   = reset && (w_branch || w_stall);
  assign memWbBubble = reset && w_freeze;
  assign busy        = reset && w_freeze;
  assign stallCycles = r_stall;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= RUN;
      r_wait_cnt <= 4'd0;
      r_stall    <= '0;
    end else begin
      if ((w_freeze || w_stall) && r_stall != '1) r_stall <= r_stall + 1'b1;
      if (r_state == RUN) begin
        if (w_freeze) begin
          r_state    <= WAIT;
          r_wait_cnt <= 4'(MEM_LATENCY - 2);
        end
      end else if (r_wait_cnt != 4'd0) r_wait_cnt <= r_wait_cnt - 4'd1;
      else r_state <= RUN;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed scoreboard bench for the hazard controller
module tb_pipeline_hazard_controller;
  logic clock = 1'b0, reset = 1'b0;
  logic [4:0] idRs = '0, idRt = '0, exRd = '0;
  logic idUsesRt = 1'b0, exMemRead = 1'b0, exBranchTaken = 1'b0, memAccess = 1'b0;
  logic pc0, ifid0, idex0, exmem0, memwb0, iffl0, idexfl0, bub0, busy0;
  logic pc1, ifid1, idex1, exmem1, memwb1, iffl1, idexfl1, bub1, busy1;
  logic [15:0] stall0;
  logic [3:0]  stall1;
  logic [8:0]  o0, o1;
  int n_chk = 0, n_fail = 0;
  // {pc, ifId, idEx, exMem, memWb, ifIdFlush, idExFlush, memWbBubble, busy}
  localparam logic [8:0] OFF = 9'b000000000, NRM = 9'b111110000, LU = 9'b001110100,
                         BR  = 9'b111111100, FRZ = 9'b000000011;
  typedef struct { string tag; logic [8:0] exp0; int st0; logic [8:0] exp1; int st1; } item_t;
  item_t sb[$];

  always #5 clock = ~clock;

  pipeline_hazard_controller dut (
    .clock(clock), .reset(reset), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
    .exMemRead(exMemRead), .exRd(exRd), .exBranchTaken(exBranchTaken), .memAccess(memAccess),
    .pcEnable(pc0), .ifIdEnable(ifid0), .idExEnable(idex0), .exMemEnable(exmem0),
    .memWbEnable(memwb0), .ifIdFlush(iffl0), .idExFlush(idexfl0), .memWbBubble(bub0),
    .busy(busy0), .stallCycles(stall0));

  pipeline_hazard_controller #(.MEM_LATENCY(1), .STALL_CNT_WIDTH(4)) dut1 (
    .clock(clock), .reset(reset), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
    .exMemRead(exMemRead), .exRd(exRd), .exBranchTaken(exBranchTaken), .memAccess(memAccess),
    .pcEnable(pc1), .ifIdEnable(ifid1), .idExEnable(idex1), .exMemEnable(exmem1),
    .memWbEnable(memwb1), .ifIdFlush(iffl1), .idExFlush(idexfl1), .memWbBubble(bub1),
    .busy(busy1), .stallCycles(stall1));

  assign o0 = {pc0, ifid0, idex0, exmem0, memwb0, iffl0, idexfl0, bub0, busy0};
  assign o1 = {pc1, ifid1, idex1, exmem1, memwb1, iffl1, idexfl1, bub1, busy1};

  task automatic set_in(input logic mr, input logic [4:0] rd, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urt, input logic br, input logic ma);
    exMemRead = mr; exRd = rd; idRs = rs; idRt = rt; idUsesRt = urt; exBranchTaken = br; memAccess = ma;
  endtask

  // st1 < 0 skips the small-counter instance's stall check
  task automatic chk(input string tag, input logic [8:0] e0, input int s0, input logic [8:0] e1, input int s1);
    item_t it;
    sb.push_back('{tag, e0, s0, e1, s1});
    @(negedge clock);
    it = sb.pop_front();
    n_chk++;
    assert (o0 === it.exp0) else begin n_fail++; $error("FAIL %s outputs got %b expected %b", it.tag, o0, it.exp0); end
    n_chk++;
    assert (stall0 === 16'(it.st0)) else begin n_fail++; $error("FAIL %s stallCycles got %0d expected %0d", it.tag, stall0, it.st0); end
    n_chk++;
    assert (o1 === it.exp1) else begin n_fail++; $error("FAIL %s lat1 outputs got %b expected %b", it.tag, o1, it.exp1); end
    if (it.st1 >= 0) begin
      n_chk++;
      assert (stall1 === 4'(it.st1)) else begin n_fail++; $error("FAIL %s lat1 stallCycles got %0d expected %0d", it.tag, stall1, it.st1); end
    end
    @(posedge clock); #1;
  endtask

  initial begin
    chk("reset", OFF, 0, OFF, 0);
    reset = 1'b1;
    chk("idle", NRM, 0, NRM, 0);
    set_in(1, 8, 8, 0, 0, 0, 0); chk("loaduse_rs", LU, 0, LU, 0);
    set_in(0, 0, 0, 0, 0, 0, 0); chk("after_lu", NRM, 1, NRM, 1);
    set_in(1, 0, 0, 0, 0, 0, 0); chk("rd_zero", NRM, 1, NRM, 1);
    set_in(1, 8, 3, 8, 0, 0, 0); chk("rt_unused", NRM, 1, NRM, 1);
    set_in(1, 8, 3, 8, 1, 0, 0); chk("loaduse_rt", LU, 1, LU, 1);
    set_in(1, 8, 8, 0, 0, 1, 0); chk("branch_over_lu", BR, 2, BR, 2);
    set_in(0, 0, 0, 0, 0, 0, 0); chk("after_br", NRM, 2, NRM, 2);
    set_in(0, 0, 0, 0, 0, 0, 1); chk("mem_c0", FRZ, 2, NRM, 2);
    chk("mem_c1", FRZ, 3, NRM, 2);
    chk("mem_release", NRM, 4, NRM, 2);
    chk("mem_b2b_c0", FRZ, 4, NRM, 2);
    set_in(1, 8, 8, 0, 0, 1, 1); chk("frz_ignores_br", FRZ, 5, BR, 2);
    set_in(0, 0, 0, 0, 0, 1, 0); chk("release_br", BR, 6, BR, 2);
    set_in(0, 0, 0, 0, 0, 0, 1); chk("mem2_c0", FRZ, 6, NRM, 2);
    chk("mem2_c1", FRZ, 7, NRM, 2);
    set_in(1, 9, 9, 0, 0, 0, 0); chk("release_lu", LU, 8, LU, 2);
    set_in(0, 0, 0, 0, 0, 0, 1); chk("mem3_c0", FRZ, 9, NRM, 3);
    reset = 1'b0; chk("reset_mid_wait", OFF, 0, OFF, 0);
    reset = 1'b1; set_in(0, 0, 0, 0, 0, 0, 0); chk("post_reset", NRM, 0, NRM, 0);
    chk("no_residual", NRM, 0, NRM, 0);
    set_in(1, 5, 5, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) chk("saturate", LU, i, LU, (i > 15) ? 15 : i);
    set_in(0, 0, 0, 0, 0, 0, 0); chk("sat_hold", NRM, 20, NRM, 15);
    chk("sat_hold2", NRM, 20, NRM, 15);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
